// File: rtl/recorrido_ram_pkg.sv
// Shared definitions for recorrido_ram and the synchronous RAM it reads.
// Holds the scan FSM encoding and the default RAM geometry.
package recorrido_ram_pkg;

   localparam int AW_RAM = 8;
   localparam int DW_RAM = 8;

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      LEER   = 2'd1,
      DRENAR = 2'd2,
      FIN    = 2'd3
   } estado_t;

endpackage

// File: rtl/recorrido_ram_acumulador_estad.sv
// Running sum / unsigned max / unsigned min / count over a word stream.
// Reusable by any reader that presents one word per enabled cycle.
module acumulador_estad #(
   parameter int DW = 8,
   parameter int CW = 9
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            en,
   input  logic [DW-1:0]   dato,
   output logic [2*DW-1:0] suma,
   output logic [DW-1:0]   maximo,
   output logic [DW-1:0]   minimo,
   output logic [CW-1:0]   conteo
);

   // min starts at all-ones so the first word always replaces it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         suma   <= '0;
         maximo <= '0;
         minimo <= '1;
         conteo <= '0;
      end else if (clear) begin
         suma   <= '0;
         maximo <= '0;
         minimo <= '1;
         conteo <= '0;
      end else if (en) begin
         suma   <= suma + {{DW{1'b0}}, dato};
         conteo <= conteo + CW'(1);
         if (dato > maximo) maximo <= dato;
         if (dato < minimo) minimo <= dato;
      end
   end

endmodule

// File: rtl/recorrido_ram.sv
// Read-only scan engine for ram_sincrona: walks dir_ini..dir_fin (wrapping),
// streams each word with a valid strobe and accumulates sum/max/min/count.
module recorrido_ram
   import recorrido_ram_pkg::*;
#(
   parameter int AW = AW_RAM,
   parameter int DW = DW_RAM
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inicio,
   input  logic [AW-1:0]   dir_ini,
   input  logic [AW-1:0]   dir_fin,
   output logic [AW-1:0]   direccion,
   output logic            EN,
   output logic [DW-1:0]   dato_e,
   input  logic [DW-1:0]   dato_s,
   output logic [DW-1:0]   dato,
   output logic            dato_v,
   output logic            ocupado,
   output logic            listo,
   output logic [2*DW-1:0] suma,
   output logic [DW-1:0]   maximo,
   output logic [DW-1:0]   minimo,
   output logic [AW:0]     conteo
);

   estado_t       estado;
   estado_t       estado_sig;
   logic [AW-1:0] fin_q;
   logic [AW:0]   restante;
   logic          drenado;
   logic          v1;
   logic          aceptar;

   assign aceptar = (estado == REPOSO) && inicio;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) estado <= REPOSO;
      else     estado <= estado_sig;
   end

   always_comb begin
      estado_sig = estado;
      case (estado)
         REPOSO:  if (inicio) estado_sig = LEER;
         LEER:    if (direccion == fin_q) estado_sig = DRENAR;
         DRENAR:  if (drenado) estado_sig = FIN;
         FIN:     estado_sig = REPOSO;
         default: estado_sig = REPOSO;
      endcase
   end

   // The RAM is never written by this block
   always_comb begin
      ocupado = (estado != REPOSO);
      listo   = (estado == FIN);
      EN      = 1'b0;
      dato_e  = '0;
   end

   // restante holds N = ((fin - ini) mod 2^AW) + 1, hence the extra bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         direccion <= '0;
         fin_q     <= '0;
         restante  <= '0;
         drenado   <= 1'b0;
      end else begin
         case (estado)
            REPOSO: begin
               if (inicio) begin
                  fin_q     <= dir_fin;
                  direccion <= dir_ini;
                  restante  <= {1'b0, dir_fin - dir_ini} + (AW+1)'(1);
               end
            end
            LEER: begin
               restante <= restante - (AW+1)'(1);
               drenado  <= 1'b0;
               if (direccion != fin_q) direccion <= direccion + AW'(1);
            end
            DRENAR:  drenado <= 1'b1;
            default: ;
         endcase
      end
   end

   // v1 marks the edge where the RAM registers dato_s; dato_v is stage 2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1     <= 1'b0;
         dato_v <= 1'b0;
         dato   <= '0;
      end else begin
         v1     <= (estado == LEER);
         dato_v <= v1;
         if (v1) dato <= dato_s;
      end
   end

   acumulador_estad #(
      .DW (DW),
      .CW (AW + 1)
   ) u_acumulador (
      .clk    (clk),
      .rst    (rst),
      .clear  (aceptar),
      .en     (v1),
      .dato   (dato_s),
      .suma   (suma),
      .maximo (maximo),
      .minimo (minimo),
      .conteo (conteo)
   );

endmodule
